// File: rtl/pong_pkg.sv
// Shared screen geometry, colors, pixel record and writer FSM encoding.
// No logic, constants and types only.
// Imported by every block that produces or consumes pixels.
package pong_pkg;

  localparam int SCR_W     = 160;
  localparam int SCR_H     = 120;
  localparam int FB_ADDR_W = 15;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
  } pixel_t;

  typedef logic [1:0] fbw_state_t;
  localparam fbw_state_t FBW_IDLE  = 2'd0;
  localparam fbw_state_t FBW_DRAIN = 2'd1;
  localparam fbw_state_t FBW_CLEAR = 2'd2;

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered pointers.
// Head entry visible on rd_data the cycle after it is written.
// Writes while full and reads while empty are ignored; caller gates on flags.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel-plot sink: FIFO-buffers drawer pixels, clips, writes framebuffer; full-screen clear.
// One cycle from acceptance to registered write; one pixel per cycle sustained.
// plot_ready drops when the FIFO is full or a clear is pending or running.
module pixel_fb_writer #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         SCR_W       = 160,
  parameter int         SCR_H       = 120,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        plot_valid,
  output logic        plot_ready,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic [2:0]  color_in,
  input  logic        clear_req,
  output logic        busy,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic [7:0]  drop_count
);

  import pong_pkg::*;

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCR_W * SCR_H - 1);

  fbw_state_t             state;
  fbw_state_t             state_nxt;
  logic                   clear_pending;
  logic [FB_ADDR_W-1:0]   clr_cnt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   in_range;
  logic [FB_ADDR_W-1:0]   pix_addr;
  pixel_t                 wr_pix;
  pixel_t                 rd_pix;

  assign plot_ready = !fifo_full && (state != FBW_CLEAR) && !clear_pending;
  assign push       = plot_valid && plot_ready;
  // The FIFO drains whenever the clear sequencer is not running, which gives
  // pixels accepted before a clear request priority over the clear.
  assign pop        = !fifo_empty && (state != FBW_CLEAR);
  assign busy       = !fifo_empty || clear_pending || (state == FBW_CLEAR);
  assign wr_pix     = {x_in, y_in, color_in};

  assign in_range = (int'(rd_pix.x) < SCR_W) && (int'(rd_pix.y) < SCR_H);
  assign pix_addr = FB_ADDR_W'(int'(rd_pix.y) * SCR_W + int'(rd_pix.x));

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (wr_pix),
    .rd_en   (pop),
    .rd_data (rd_pix),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next state: a pending clear starts only once the FIFO has emptied.
  always_comb begin
    state_nxt = state;
    case (state)
      FBW_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = FBW_IDLE;
      default: begin
        if (!fifo_empty)        state_nxt = FBW_DRAIN;
        else if (clear_pending) state_nxt = FBW_CLEAR;
        else                    state_nxt = FBW_IDLE;
      end
    endcase
  end

  // FSM, clear request latch and clear address counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= FBW_IDLE;
      clear_pending <= 1'b0;
      clr_cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (state == FBW_CLEAR) begin
        clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) clear_pending <= 1'b0;
      end else if (clear_req) begin
        clear_pending <= 1'b1;
      end
    end
  end

  // Registered framebuffer port and saturating clip counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      drop_count <= '0;
    end else begin
      mem_we <= 1'b0;
      if (state == FBW_CLEAR) begin
        mem_we   <= 1'b1;
        mem_addr <= clr_cnt;
        mem_data <= CLEAR_COLOR;
      end else if (pop) begin
        if (in_range) begin
          mem_we   <= 1'b1;
          mem_addr <= pix_addr;
          mem_data <= rd_pix.color;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer with a queue-based write model.
// Expected writes are queued in acceptance order; clears append 19200 entries.
// Every cycle with mem_we high is checked against the head of the queue.
module tb_pixel_fb_writer;

  logic        clk;
  logic        resetn;
  logic        plot_valid;
  logic        plot_ready;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  color_in;
  logic        clear_req;
  logic        busy;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic [7:0]  drop_count;

  pixel_fb_writer #(
    .FIFO_DEPTH  (8),
    .SCR_W       (160),
    .SCR_H       (120),
    .CLEAR_COLOR (3'b000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .plot_valid (plot_valid),
    .plot_ready (plot_ready),
    .x_in       (x_in),
    .y_in       (y_in),
    .color_in   (color_in),
    .clear_req  (clear_req),
    .busy       (busy),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .drop_count (drop_count)
  );

  typedef struct {
    int addr;
    int data;
    bit clr;
  } exp_t;

  exp_t expq[$];
  int   total     = 0;
  int   bad       = 0;
  int   drop_exp  = 0;
  int   clr_left  = 0;
  int   wr_count  = 0;
  int   last_addr = -1;
  bit   chk_en    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model of one accepted pixel: in-range pixels become a write, others a drop.
  task automatic model_pixel(input int x, input int y, input int c);
    exp_t e;
    if (x < 160 && y < 120) begin
      e.addr = y * 160 + x;
      e.data = c;
      e.clr  = 1'b0;
      expq.push_back(e);
    end else if (drop_exp < 255) begin
      drop_exp++;
    end
  endtask

  // Model of a clear request: the whole screen in address order, after queued pixels.
  task automatic model_clear();
    exp_t e;
    if (clr_left == 0) begin
      for (int i = 0; i < 19200; i++) begin
        e.addr = i;
        e.data = 0;
        e.clr  = 1'b1;
        expq.push_back(e);
      end
      clr_left = 19200;
    end
  endtask

  // Compare process: every write must match the model, and no pixel may be
  // accepted while a clear is pending or running.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (mem_we) begin
        wr_count++;
        last_addr = int'(mem_addr);
        if (expq.size() == 0) begin
          check("unexpected_write_addr", int'(mem_addr), -1);
        end else begin
          e = expq.pop_front();
          check("write_addr", int'(mem_addr), e.addr);
          check("write_data", int'(mem_data), e.data);
          if (e.clr) clr_left--;
        end
      end
      if (clr_left > 0) check("ready_low_during_clear", int'(plot_ready), 0);
    end
  end

  // Present one pixel (optionally with a clear pulse on the first edge) and
  // wait, bounded, for it to be accepted.
  task automatic push(input int x, input int y, input int c, input bit clr);
    bit acc = 1'b0;
    int n   = 0;
    plot_valid = 1'b1;
    x_in       = 8'(x);
    y_in       = 7'(y);
    color_in   = 3'(c);
    clear_req  = clr;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = plot_ready;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      n++;
    end
    plot_valid = 1'b0;
    if (!acc) check("push_accept", 0, 1);
    else model_pixel(x, y, c);
    if (clr) model_clear();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("busy_idle", int'(busy), 0);
    @(posedge clk);
    #1;
    check("pending_writes", expq.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_data", int'(mem_data), 0);
    check("rst_drop_count", int'(drop_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_plot_ready", int'(plot_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bit found;
    resetn     = 1'b0;
    plot_valid = 1'b0;
    x_in       = '0;
    y_in       = '0;
    color_in   = '0;
    clear_req  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;

    // Single pixel: write appears one edge after acceptance, lasts one cycle.
    push(61, 27, 6, 1'b0);
    @(negedge clk);
    check("t1_no_write_yet", int'(mem_we), 0);
    @(negedge clk);
    check("t1_mem_we", int'(mem_we), 1);
    check("t1_mem_addr", int'(mem_addr), 4381);
    check("t1_mem_data", int'(mem_data), 6);
    check("t1_busy_low", int'(busy), 0);
    @(negedge clk);
    check("t1_single_write", int'(mem_we), 0);
    wait_idle(50);

    // Twenty back-to-back pixels, all written in order.
    w0 = wr_count;
    for (int i = 0; i < 20; i++) push((i * 7 + 3) % 160, (i * 5 + 1) % 120, i % 8, 1'b0);
    wait_idle(100);
    check("t2_write_count", wr_count - w0, 20);

    // Clipping at both edges plus the bottom-right corner.
    push(160, 0, 1, 1'b0);
    push(0, 120, 2, 1'b0);
    push(159, 119, 5, 1'b0);
    wait_idle(50);
    check("t3_drop_two", int'(drop_count), 2);
    check("t3_drop_model", int'(drop_count), drop_exp);
    check("t3_last_addr", last_addr, 19199);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) push(160 + (i % 96), i % 128, i % 8, 1'b0);
    wait_idle(50);
    check("t3_drop_sat", int'(drop_count), 255);
    check("t3_drop_sat_model", int'(drop_count), drop_exp);

    // Clear ordering: third pixel and clear request on the same edge.
    w0 = wr_count;
    push(10, 10, 1, 1'b0);
    push(20, 5, 2, 1'b0);
    push(159, 0, 7, 1'b1);
    wait_idle(25000);
    check("t4_write_count", wr_count - w0, 19203);
    check("t4_last_addr", last_addr, 19199);

    // Reset in the middle of a clear.
    @(posedge clk);
    #1;
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    model_clear();
    found = 1'b0;
    for (int n = 0; n < 6000 && !found; n++) begin
      @(posedge clk);
      #1;
      if (mem_we && mem_addr == 15'd5000) found = 1'b1;
    end
    check("t5_reached_5000", int'(found), 1);
    chk_en = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values();
    expq.delete();
    clr_left = 0;
    drop_exp = 0;
    @(posedge clk);
    #1;
    check("t5_still_idle", int'(mem_we), 0);
    resetn = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Normal operation after the abort.
    w0 = wr_count;
    push(5, 1, 3, 1'b0);
    wait_idle(50);
    check("t5_write_count", wr_count - w0, 1);
    check("t5_last_addr", last_addr, 165);
    check("t5_drop_zero", int'(drop_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
